axi4_lite_master: RTL and testbench
===================================

Name: axi4_lite_master

Overview:
- Single-outstanding AXI4-Lite master (initiator), the counterpart to the team's AXI4-Lite slave.
- Accepts simple register commands (read or write) from local logic on a valid/ready port.
- Drives the AXI4-Lite AW/W/B/AR/R channels and returns read data and response on a valid/ready response port.
- Used by bench drivers and by on-chip config sequencers.

Parameters:
ADDR_WIDTH, 32, address width of cmd and AW/AR channels
DATA_WIDTH, 32, data width (32 or 64); strobe width is DATA_WIDTH/8
TIMEOUT_CYCLES, 256, wait-cycle limit (used only with the optional feature)

Ports:
i_clock  in  1  clock
i_areset_n  in  1  asynchronous active-low reset
i_cmd_valid  in  1  command valid
o_cmd_ready  out  1  command accepted when high with valid
i_cmd_write  in  1  1=write, 0=read
i_cmd_addr  in  ADDR_WIDTH  byte address
i_cmd_wdata  in  DATA_WIDTH  write data
i_cmd_wstrb  in  DATA_WIDTH/8  write strobes
o_rsp_valid  out  1  response valid
i_rsp_ready  in  1  response consumed
o_rsp_write  out  1  response belongs to a write
o_rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
o_rsp_resp  out  2  BRESP/RRESP
o_awaddr, o_awprot(3), o_awvalid, i_awready  AW channel
o_wdata, o_wstrb, o_wvalid, i_wready  W channel
i_bresp(2), i_bvalid, o_bready  B channel
o_araddr, o_arprot(3), o_arvalid, i_arready  AR channel
i_rdata, i_rresp(2), i_rvalid, o_rready  R channel
o_timeout  out  1  optional; see Optional Feature

Behaviour:
- Reset: every valid/ready output 0; addr/data/strobe/rsp fields 0; state IDLE. Reset is asynchronous; mid-transaction reset abandons the transfer without a response.
- All outputs are registered; AXI outputs never combinationally depend on AXI inputs.
- *prot is constant 3'b000.
- States: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RSP.
- IDLE: o_cmd_ready=1. On valid&ready, capture the command.
  - Write: next cycle o_awvalid=o_wvalid=1, go to WR_ADDR_DATA.
  - Read: o_arvalid=1, go to RD_ADDR.
- WR_ADDR_DATA: AW and W complete independently. Each valid drops the cycle after its own handshake and stays low. When both are done (including same-cycle completion), set o_bready=1 and go to WR_RESP.
- WR_RESP: on i_bvalid&o_bready, latch bresp, set o_bready=0, rdata=0, o_rsp_write=1, go to RSP.
- RD_ADDR: on i_arready, set o_arvalid=0, o_rready=1, go to RD_DATA.
- RD_DATA: on i_rvalid, latch rdata/rresp, set o_rready=0, o_rsp_write=0, go to RSP.
- RSP: o_rsp_valid=1 and fields held stable until i_rsp_ready. Then return to IDLE with o_cmd_ready=1 the following cycle.
- o_cmd_ready is 0 in every state except IDLE; only one transaction is outstanding.
- Valids, once asserted, are never dropped before their handshake (AXI rule).
- Early B/R (before the address handshake) cannot be accepted because bready/rready are still low; the slave must hold its response.
- Minimum latency with ready-always-high slave and consumer: cmd accept to o_rsp_valid = 3 cycles for writes and reads.

Optional Feature:
- Macro AXI4_LITE_MASTER_TIMEOUT_EN.
- When defined:
  - An internal counter ($clog2(TIMEOUT_CYCLES+1) bits) clears on command accept and increments each cycle in WR_ADDR_DATA, WR_RESP, RD_ADDR or RD_DATA, saturating.
  - When it reaches TIMEOUT_CYCLES, o_timeout sets and stays set (sticky) until the next command accept.
  - The transaction itself continues unchanged (no protocol violation).
- When undefined: no counter; o_timeout is tied to 0.

Test Plan:
- Write addr=0x10, wdata=0xDEADBEEF, wstrb=0xF, slave ready always high, bresp=OKAY -> AW/W seen with those values in one handshake; o_rsp_valid 3 cycles after accept; resp=0, o_rsp_write=1.
- Read addr=0x20, slave returns 0x12345678 with rresp=SLVERR after 5-cycle arready delay -> o_rsp_rdata=0x12345678, o_rsp_resp=2'b10, o_rsp_write=0; arvalid held for all 5 cycles.
- Write with awready delayed 4 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held 4 cycles, bready asserts only after both handshakes.
- i_rsp_ready held low for 10 cycles -> response fields and o_rsp_valid stable; o_cmd_ready stays 0 and a new cmd_valid is not accepted.
- Assert i_areset_n low during WR_RESP -> all valids/readies 0 immediately; next command after reset completes normally.
- With AXI4_LITE_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=8, bvalid delayed 20 cycles -> o_timeout rises on wait cycle 8 and the transaction still completes; o_timeout clears on the next command accept.

Source files
------------

// File: rtl/axi4_lite_master.sv
// AXI4-Lite single-outstanding master: local cmd/rsp handshake port driving AW/W/B/AR/R.
// Optional wait-cycle watchdog (o_timeout) is built when AXI4_LITE_MASTER_TIMEOUT_EN is defined.
module axi4_lite_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    i_clock,
    input  logic                    i_areset_n,
    input  logic                    i_cmd_valid,
    output logic                    o_cmd_ready,
    input  logic                    i_cmd_write,
    input  logic [ADDR_WIDTH-1:0]   i_cmd_addr,
    input  logic [DATA_WIDTH-1:0]   i_cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_cmd_wstrb,
    output logic                    o_rsp_valid,
    input  logic                    i_rsp_ready,
    output logic                    o_rsp_write,
    output logic [DATA_WIDTH-1:0]   o_rsp_rdata,
    output logic [1:0]              o_rsp_resp,
    output logic [ADDR_WIDTH-1:0]   o_awaddr,
    output logic [2:0]              o_awprot,
    output logic                    o_awvalid,
    input  logic                    i_awready,
    output logic [DATA_WIDTH-1:0]   o_wdata,
    output logic [DATA_WIDTH/8-1:0] o_wstrb,
    output logic                    o_wvalid,
    input  logic                    i_wready,
    input  logic [1:0]              i_bresp,
    input  logic                    i_bvalid,
    output logic                    o_bready,
    output logic [ADDR_WIDTH-1:0]   o_araddr,
    output logic [2:0]              o_arprot,
    output logic                    o_arvalid,
    input  logic                    i_arready,
    input  logic [DATA_WIDTH-1:0]   i_rdata,
    input  logic [1:0]              i_rresp,
    input  logic                    i_rvalid,
    output logic                    o_rready,
    output logic                    o_timeout
);

    // state        | meaning
    // IDLE         | cmd_ready high, waiting for a command
    // WR_ADDR_DATA | AW and W offered, each retired independently
    // WR_RESP      | bready high, waiting for B
    // RD_ADDR      | arvalid high, waiting for arready
    // RD_DATA      | rready high, waiting for R
    // RSP          | rsp_valid high until consumed
    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        RSP
    } state_t;

    state_t                  state_q, state_d;
    logic                    cmd_ready_q, cmd_ready_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    bready_q, bready_d;
    logic                    arvalid_q, arvalid_d;
    logic                    rready_q, rready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    rsp_write_q, rsp_write_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]              rsp_resp_q, rsp_resp_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
    logic                    cmd_accept;
    logic                    aw_done, w_done;

    assign cmd_accept = (state_q == IDLE) && i_cmd_valid && cmd_ready_q;
    assign aw_done    = !awvalid_q || i_awready;
    assign w_done     = !wvalid_q || i_wready;

    always_comb begin
        state_d     = state_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        case (state_q)
            IDLE: begin
                if (cmd_accept) begin
                    addr_d = i_cmd_addr;
                    if (i_cmd_write) begin
                        wdata_d   = i_cmd_wdata;
                        wstrb_d   = i_cmd_wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_ADDR_DATA;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = RD_ADDR;
                    end
                end
            end
            WR_ADDR_DATA: begin
                if (awvalid_q && i_awready) awvalid_d = 1'b0;
                if (wvalid_q && i_wready)   wvalid_d  = 1'b0;
                if (aw_done && w_done) begin
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (i_bvalid && bready_q) begin
                    bready_d    = 1'b0;
                    rsp_resp_d  = i_bresp;
                    rsp_rdata_d = '0;
                    rsp_write_d = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = RSP;
                end
            end
            RD_ADDR: begin
                if (arvalid_q && i_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (i_rvalid && rready_q) begin
                    rready_d    = 1'b0;
                    rsp_rdata_d = i_rdata;
                    rsp_resp_d  = i_rresp;
                    rsp_write_d = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RSP;
                end
            end
            RSP: begin
                if (i_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        cmd_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge i_clock or negedge i_areset_n) begin
        if (!i_areset_n) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
        end
    end

    assign o_cmd_ready = cmd_ready_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_write = rsp_write_q;
    assign o_rsp_rdata = rsp_rdata_q;
    assign o_rsp_resp  = rsp_resp_q;
    assign o_awaddr    = addr_q;
    assign o_awprot    = 3'b000;
    assign o_awvalid   = awvalid_q;
    assign o_wdata     = wdata_q;
    assign o_wstrb     = wstrb_q;
    assign o_wvalid    = wvalid_q;
    assign o_bready    = bready_q;
    assign o_araddr    = addr_q;
    assign o_arprot    = 3'b000;
    assign o_arvalid   = arvalid_q;
    assign o_rready    = rready_q;

`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          timeout_q, timeout_d;
    logic          busy;

    assign busy = (state_q == WR_ADDR_DATA) || (state_q == WR_RESP) ||
                  (state_q == RD_ADDR) || (state_q == RD_DATA);

    // Counter saturates at the limit so the flag stays sticky for long stalls.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        timeout_d = timeout_q;
        if (cmd_accept) begin
            tmo_cnt_d = '0;
            timeout_d = 1'b0;
        end else begin
            if (busy && (tmo_cnt_q != TMO_MAX)) tmo_cnt_d = tmo_cnt_q + 1'b1;
            if (tmo_cnt_d == TMO_MAX) timeout_d = 1'b1;
        end
    end

    always_ff @(posedge i_clock or negedge i_areset_n) begin
        if (!i_areset_n) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_timeout = timeout_q;
`else
    // Watchdog absent: flag is a constant low; the limit parameter has no effect.
    assign o_timeout = 1'b0 & (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_axi4_lite_master.sv
// Scoreboard bench for axi4_lite_master with a configurable-latency AXI4-Lite slave model.
// Timeout expectations follow AXI4_LITE_MASTER_TIMEOUT_EN as defined for the build.
module tb_axi4_lite_master;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
    localparam logic TMO_EN = 1'b1;
`else
    localparam logic TMO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_cmd_valid, o_cmd_ready, i_cmd_write;
    logic [AW-1:0] i_cmd_addr;
    logic [DW-1:0] i_cmd_wdata;
    logic [SW-1:0] i_cmd_wstrb;
    logic          o_rsp_valid, i_rsp_ready, o_rsp_write;
    logic [DW-1:0] o_rsp_rdata;
    logic [1:0]    o_rsp_resp;
    logic [AW-1:0] o_awaddr, o_araddr;
    logic [2:0]    o_awprot, o_arprot;
    logic          o_awvalid, i_awready, o_wvalid, i_wready;
    logic [DW-1:0] o_wdata, i_rdata;
    logic [SW-1:0] o_wstrb;
    logic [1:0]    i_bresp, i_rresp;
    logic          i_bvalid, o_bready, o_arvalid, i_arready, i_rvalid, o_rready;
    logic          o_timeout;

    always #5 clk = ~clk;

    axi4_lite_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)) dut (
        .i_clock(clk), .i_areset_n(rst_n),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_write(i_cmd_write),
        .i_cmd_addr(i_cmd_addr), .i_cmd_wdata(i_cmd_wdata), .i_cmd_wstrb(i_cmd_wstrb),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_write(o_rsp_write),
        .o_rsp_rdata(o_rsp_rdata), .o_rsp_resp(o_rsp_resp),
        .o_awaddr(o_awaddr), .o_awprot(o_awprot), .o_awvalid(o_awvalid), .i_awready(i_awready),
        .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wvalid(o_wvalid), .i_wready(i_wready),
        .i_bresp(i_bresp), .i_bvalid(i_bvalid), .o_bready(o_bready),
        .o_araddr(o_araddr), .o_arprot(o_arprot), .o_arvalid(o_arvalid), .i_arready(i_arready),
        .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rvalid(i_rvalid), .o_rready(o_rready),
        .o_timeout(o_timeout)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // slave model configuration and expected channel payloads
    int            aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0;
    logic [DW-1:0] slv_rdata = '0;
    logic [1:0]    slv_bresp = 2'b00, slv_rresp = 2'b00;
    logic [AW-1:0] exp_addr = '0;
    logic [DW-1:0] exp_wdata = '0;
    logic [SW-1:0] exp_wstrb = '0;

    int aw_hi = 0, w_hi = 0, ar_hi = 0, bready_early = 0, drop_viol = 0;

    initial begin
        bit aw_hs, w_hs, ar_hs, b_hs, r_hs;
        bit pv_aw, pv_w, pv_ar;
        bit aw_seen, w_seen, ar_seen;
        int aw_wait, w_wait, ar_wait, b_wait;
        {aw_hs, w_hs, ar_hs, b_hs, r_hs, pv_aw, pv_w, pv_ar, aw_seen, w_seen, ar_seen} = '0;
        {aw_wait, w_wait, ar_wait, b_wait} = '0;
        i_awready = 0; i_wready = 0; i_arready = 0; i_bvalid = 0; i_rvalid = 0;
        i_bresp = 0; i_rresp = 0; i_rdata = 0;
        forever begin
            @(negedge clk);
            aw_hs = o_awvalid && i_awready;
            w_hs  = o_wvalid && i_wready;
            ar_hs = o_arvalid && i_arready;
            b_hs  = i_bvalid && o_bready;
            r_hs  = i_rvalid && o_rready;
            if (rst_n) begin
                if (o_awvalid) aw_hi++;
                if (o_wvalid) w_hi++;
                if (o_arvalid) ar_hi++;
                if (o_bready && (o_awvalid || o_wvalid)) bready_early++;
                if ((pv_aw && !o_awvalid) || (pv_w && !o_wvalid) || (pv_ar && !o_arvalid)) drop_viol++;
                pv_aw = o_awvalid && !aw_hs;
                pv_w  = o_wvalid && !w_hs;
                pv_ar = o_arvalid && !ar_hs;
                if (aw_hs) begin
                    check_eq("awaddr", o_awaddr, exp_addr);
                    check_eq("awprot", o_awprot, 3'b000);
                end
                if (w_hs) begin
                    check_eq("wdata", o_wdata, exp_wdata);
                    check_eq("wstrb", o_wstrb, exp_wstrb);
                end
                if (ar_hs) begin
                    check_eq("araddr", o_araddr, exp_addr);
                    check_eq("arprot", o_arprot, 3'b000);
                end
            end else begin
                {pv_aw, pv_w, pv_ar} = '0;
            end
            @(posedge clk);
            #1;
            if (!rst_n) begin
                i_awready = 0; i_wready = 0; i_arready = 0; i_bvalid = 0; i_rvalid = 0;
                {aw_seen, w_seen, ar_seen} = '0;
                {aw_wait, w_wait, ar_wait, b_wait} = '0;
                continue;
            end
            // responses use the handshake state from the previous cycle: one cycle of slave latency
            if (b_hs) begin
                i_bvalid = 0; aw_seen = 0; w_seen = 0; b_wait = 0;
            end else if (aw_seen && w_seen && !i_bvalid) begin
                if (b_wait >= b_dly) begin i_bvalid = 1; i_bresp = slv_bresp; end
                else b_wait++;
            end
            if (r_hs) begin
                i_rvalid = 0; ar_seen = 0;
            end else if (ar_seen && !i_rvalid) begin
                i_rvalid = 1; i_rdata = slv_rdata; i_rresp = slv_rresp;
            end
            if (aw_hs) begin i_awready = 0; aw_wait = 0; aw_seen = 1; end
            else if (o_awvalid) begin i_awready = (aw_wait >= aw_dly - 1); aw_wait++; end
            if (w_hs) begin i_wready = 0; w_wait = 0; w_seen = 1; end
            else if (o_wvalid) begin i_wready = (w_wait >= w_dly - 1); w_wait++; end
            if (ar_hs) begin i_arready = 0; ar_wait = 0; ar_seen = 1; end
            else if (o_arvalid) begin i_arready = (ar_wait >= ar_dly - 1); ar_wait++; end
        end
    end

    typedef struct packed {
        logic          wr;
        logic [DW-1:0] rdata;
        logic [1:0]    resp;
    } rsp_t;

    rsp_t exp_q[$];
    int   rsp_cnt = 0;
    int   target_cnt = 0;
    int   acc_cyc = 0;

    always @(negedge clk) begin
        if (rst_n && o_rsp_valid && i_rsp_ready) begin
            rsp_t e;
            check_eq("rsp_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_eq("rsp_write", o_rsp_write, e.wr);
                check_eq("rsp_rdata", o_rsp_rdata, e.rdata);
                check_eq("rsp_resp", o_rsp_resp, e.resp);
            end
            rsp_cnt++;
        end
    end

    task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input logic [SW-1:0] wstrb);
        int   n = 0;
        rsp_t e;
        exp_addr = addr; exp_wdata = wdata; exp_wstrb = wstrb;
        i_cmd_write = wr; i_cmd_addr = addr; i_cmd_wdata = wdata; i_cmd_wstrb = wstrb;
        i_cmd_valid = 1;
        @(negedge clk);
        while (!o_cmd_ready && n < 50) begin @(negedge clk); n++; end
        check_eq("cmd_accept", o_cmd_ready, 1);
        e.wr    = wr;
        e.rdata = wr ? '0 : slv_rdata;
        e.resp  = wr ? slv_bresp : slv_rresp;
        exp_q.push_back(e);
        target_cnt = rsp_cnt + 1;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        i_cmd_valid = 0;
    endtask

    task automatic wait_rsp(input int exp_lat);
        int n = 0;
        while (!o_rsp_valid && n < 200) begin @(posedge clk); #1; n++; end
        check_eq("rsp_valid_rise", o_rsp_valid, 1);
        if (exp_lat >= 0) check_eq("rsp_latency", cyc - acc_cyc, exp_lat);
        n = 0;
        while (rsp_cnt < target_cnt && n < 200) begin @(posedge clk); #1; n++; end
        check_eq("rsp_consumed", rsp_cnt >= target_cnt, 1);
    endtask

    task automatic clear_mon();
        aw_hi = 0; w_hi = 0; ar_hi = 0; bready_early = 0;
    endtask

    initial begin
        int n;
        i_cmd_valid = 0; i_cmd_write = 0; i_cmd_addr = '0; i_cmd_wdata = '0; i_cmd_wstrb = '0;
        i_rsp_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_handshakes",
                 {o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready, o_rsp_valid, o_cmd_ready}, '0);
        check_eq("reset_fields", {o_awaddr, o_wdata, o_wstrb, o_rsp_rdata, o_rsp_resp, o_rsp_write}, '0);
        check_eq("reset_timeout", o_timeout, 0);
        @(negedge clk);
        rst_n = 1;

        // single-cycle write, OKAY
        clear_mon();
        issue(1, 32'h10, 32'hDEADBEEF, 4'hF);
        wait_rsp(3);
        check_eq("wr1_aw_cycles", aw_hi, 1);
        check_eq("wr1_w_cycles", w_hi, 1);

        // read with 5-cycle arready delay, SLVERR
        clear_mon();
        ar_dly = 5; slv_rdata = 32'h12345678; slv_rresp = 2'b10;
        issue(0, 32'h20, '0, '0);
        wait_rsp(7);
        check_eq("rd_ar_cycles", ar_hi, 5);
        ar_dly = 0;

        // write with awready late, wready immediate
        clear_mon();
        aw_dly = 4; slv_bresp = 2'b01;
        issue(1, 32'h34, 32'hA5A5_0F0F, 4'b0110);
        wait_rsp(6);
        check_eq("wr2_aw_cycles", aw_hi, 4);
        check_eq("wr2_w_cycles", w_hi, 1);
        check_eq("wr2_bready_early", bready_early, 0);
        aw_dly = 0; slv_bresp = 2'b00;

        // consumer stalls 10 cycles while a second command is offered
        slv_rdata = 32'hCAFE_F00D; slv_rresp = 2'b00;
        i_rsp_ready = 0;
        issue(0, 32'h48, '0, '0);
        n = 0;
        while (!o_rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
        i_cmd_write = 1; i_cmd_addr = 32'h99; i_cmd_valid = 1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check_eq("stall_rsp_valid", o_rsp_valid, 1);
            check_eq("stall_rsp_fields", {o_rsp_write, o_rsp_rdata, o_rsp_resp}, {1'b0, 32'hCAFE_F00D, 2'b00});
            check_eq("stall_no_accept", {o_cmd_ready, o_awvalid, o_arvalid}, 3'b000);
        end
        i_cmd_valid = 0;
        i_rsp_ready = 1;
        wait_rsp(-1);

        // asynchronous reset while waiting for B
        b_dly = 30;
        issue(1, 32'h40, 32'h1111_2222, 4'hF);
        n = 0;
        while (!o_bready && n < 20) begin @(posedge clk); #1; n++; end
        check_eq("rst_reached_wr_resp", o_bready, 1);
        @(posedge clk);
        #2;
        rst_n = 0;
        #1;
        check_eq("rst_mid_handshakes",
                 {o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready, o_rsp_valid, o_cmd_ready}, '0);
        check_eq("rst_mid_addr", o_awaddr, '0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1;
        b_dly = 0;
        issue(1, 32'h44, 32'h3333_4444, 4'h3);
        wait_rsp(3);

        // long B stall: watchdog flag behaviour
        b_dly = 20;
        issue(1, 32'h50, 32'h5555_6666, 4'hF);
        repeat (7) begin @(posedge clk); #1; end
        check_eq("timeout_before_limit", o_timeout, 0);
        @(posedge clk);
        #1;
        check_eq("timeout_at_limit", o_timeout, TMO_EN);
        wait_rsp(23);
        check_eq("timeout_sticky", o_timeout, TMO_EN);
        b_dly = 0;
        issue(0, 32'h60, '0, '0);
        check_eq("timeout_clear_on_accept", o_timeout, 0);
        wait_rsp(3);

        check_eq("valid_drop_violations", drop_viol, 0);
        check_eq("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
